// File: rtl/spi_cmd_engine_if.sv
// Signal bundle between the SD-card command sequencer and the SPI shift engine.
// The engine side is "master" because it drives the SPI bus; the sequencer/card side is "slave".
interface spi_cmd_engine_if #(
  parameter int FRAME_BITS = 48
);
  logic [FRAME_BITS-1:0] data;
  logic [8:0]            status;
  logic                  miso;
  logic                  sck;
  logic                  mosi;
  logic                  ss;
  logic [7:0]            r1;
  logic [31:0]           resp;
  logic [2:0]            flag;

  modport master (
    input  data, status, miso,
    output sck, mosi, ss, r1, resp, flag
  );

  modport slave (
    output data, status, miso,
    input  sck, mosi, ss, r1, resp, flag
  );
endinterface

// File: rtl/spi_cmd_engine.sv
// Mode-0 SPI master for SD-card commands: shifts a 48-bit frame, waits for R1,
// optionally collects a 32-bit R3/R7 trailer, and reports done/timeout.
module spi_cmd_engine #(
  parameter int NCR_MAX    = 8,
  parameter int FRAME_BITS = 48
) (
  input  logic                  spi_clk_i,
  input  logic                  spi_rst_ni,
  input  logic [FRAME_BITS-1:0] spi_data_i,
  input  logic [8:0]            spi_statusreg_i,
  input  logic                  spi_miso_i,
  output logic                  SCK_SPI,
  output logic                  spi_mosi_o,
  output logic                  spi_ss_o,
  output logic [7:0]            R1,
  output logic [31:0]           spi_resp_o,
  output logic [2:0]            spi_flagreg_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_CMD,
    S_WAIT_R1,
    S_SHIFT_RESP,
    S_DONE,
    S_TOUT
  } state_e;

  localparam logic [2:0] FLAG_IDLE = 3'b000;
  localparam logic [2:0] FLAG_BUSY = 3'b001;
  localparam logic [2:0] FLAG_DONE = 3'b010;
  localparam logic [2:0] FLAG_TOUT = 3'b100;

  localparam int CNT_W  = $clog2(((FRAME_BITS > 32) ? FRAME_BITS : 32) + 1);
  localparam int BYTE_W = $clog2(NCR_MAX + 1);

  localparam logic [CNT_W-1:0]  CMD_BITS  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  BYTE_BITS = CNT_W'(8);
  localparam logic [CNT_W-1:0]  RESP_BITS = CNT_W'(32);
  localparam logic [BYTE_W-1:0] NCR_LAST  = BYTE_W'(NCR_MAX - 1);

  state_e                state_q;
  logic [FRAME_BITS-1:0] data_q;
  logic [2:0]            sel_q;
  logic                  long_q;
  logic                  msb_first_q;
  logic                  cmd_valid_q;
  logic                  sck_q;
  logic                  mosi_q;
  logic                  ss_q;
  logic [7:0]            r1_q;
  logic [31:0]           resp_q;
  logic [2:0]            flag_q;
  logic [6:0]            div_cnt_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [BYTE_W-1:0]     byte_cnt_q;
  logic [7:0]            rx_q;

  logic [6:0] half_last;
  logic       active;
  logic       half_tick;
  logic       rise;
  logic       fall;
  logic       start;
  logic       unused_status;

  assign unused_status = ^spi_statusreg_i[4:3];

  // NOTE: every signal gets a value at the top of the block so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    half_last = 7'((8'd1 << sel_q) - 8'd1);
    active    = (state_q == S_SHIFT_CMD) || (state_q == S_WAIT_R1) ||
                (state_q == S_SHIFT_RESP);
    half_tick = active && (div_cnt_q == half_last);
    rise      = half_tick && !sck_q;
    fall      = half_tick && sck_q;
    // Starting straight out of DONE lets a held request chain commands with no idle gap.
    start     = spi_statusreg_i[0] && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  // NOTE: all state updates use non-blocking assignment so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge spi_clk_i or negedge spi_rst_ni) begin
    if (!spi_rst_ni) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      sel_q       <= '0;
      long_q      <= 1'b0;
      msb_first_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b1;
      ss_q        <= 1'b1;
      r1_q        <= 8'hFF;
      resp_q      <= '0;
      flag_q      <= FLAG_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      rx_q        <= '0;
    end else if (start) begin
      data_q      <= spi_data_i;
      sel_q       <= spi_statusreg_i[8:6];
      long_q      <= spi_statusreg_i[5];
      msb_first_q <= spi_statusreg_i[2];
      ss_q        <= spi_statusreg_i[1];
      cmd_valid_q <= (spi_data_i[FRAME_BITS-1 -: 2] == 2'b01);
      mosi_q      <= spi_statusreg_i[2] ? spi_data_i[FRAME_BITS-1] : spi_data_i[0];
      sck_q       <= 1'b0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      rx_q        <= '0;
      flag_q      <= FLAG_BUSY;
      state_q     <= S_SHIFT_CMD;
    end else begin
      if (half_tick) begin
        sck_q     <= ~sck_q;
        div_cnt_q <= '0;
      end else if (active) begin
        div_cnt_q <= div_cnt_q + 7'd1;
      end

      if (rise) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        rx_q      <= {rx_q[6:0], spi_miso_i};
      end

      case (state_q)
        S_SHIFT_CMD: begin
          if (fall) begin
            if (bit_cnt_q == CMD_BITS) begin
              bit_cnt_q <= '0;
              mosi_q    <= 1'b1;
              if (cmd_valid_q) begin
                state_q <= S_WAIT_R1;
              end else begin
                r1_q    <= 8'hFF;
                flag_q  <= FLAG_DONE;
                state_q <= S_DONE;
              end
            end else if (msb_first_q) begin
              data_q <= data_q << 1;
              mosi_q <= data_q[FRAME_BITS-2];
            end else begin
              data_q <= data_q >> 1;
              mosi_q <= data_q[1];
            end
          end
        end

        S_WAIT_R1: begin
          if (fall && (bit_cnt_q == BYTE_BITS)) begin
            bit_cnt_q <= '0;
            if (!rx_q[7]) begin
              r1_q <= rx_q;
              if (long_q) begin
                state_q <= S_SHIFT_RESP;
              end else begin
                flag_q  <= FLAG_DONE;
                state_q <= S_DONE;
              end
            end else if (byte_cnt_q == NCR_LAST) begin
              byte_cnt_q <= byte_cnt_q + BYTE_W'(1);
              r1_q       <= 8'hFF;
              flag_q     <= FLAG_TOUT;
              state_q    <= S_TOUT;
            end else begin
              byte_cnt_q <= byte_cnt_q + BYTE_W'(1);
            end
          end
        end

        S_SHIFT_RESP: begin
          if (rise) begin
            resp_q <= {resp_q[30:0], spi_miso_i};
          end
          if (fall && (bit_cnt_q == RESP_BITS)) begin
            bit_cnt_q <= '0;
            flag_q    <= FLAG_DONE;
            state_q   <= S_DONE;
          end
        end

        S_DONE, S_TOUT: begin
          flag_q  <= FLAG_IDLE;
          state_q <= S_IDLE;
        end

        default: ;
      endcase
    end
  end

  assign SCK_SPI       = sck_q;
  assign spi_mosi_o    = mosi_q;
  assign spi_ss_o      = ss_q;
  assign R1            = r1_q;
  assign spi_resp_o    = resp_q;
  assign spi_flagreg_o = flag_q;

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Directed bench for spi_cmd_engine: a behavioural SD card answers on MISO and
// every SCK rise captures MOSI for frame reconstruction.
module tb_spi_cmd_engine;

  logic clk;
  logic rst_n;

  spi_cmd_engine_if #(.FRAME_BITS(48)) bus ();

  spi_cmd_engine #(.NCR_MAX(8), .FRAME_BITS(48)) dut (
    .spi_clk_i       (clk),
    .spi_rst_ni      (rst_n),
    .spi_data_i      (bus.data),
    .spi_statusreg_i (bus.status),
    .spi_miso_i      (bus.miso),
    .SCK_SPI         (bus.sck),
    .spi_mosi_o      (bus.mosi),
    .spi_ss_o        (bus.ss),
    .R1              (bus.r1),
    .spi_resp_o      (bus.resp),
    .spi_flagreg_o   (bus.flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   vectors     = 0;
  int   miscompares = 0;
  int   rise_cnt    = 0;
  logic mosi_cap[$];
  time  rise_t[$];
  logic card_bits[$];

  localparam logic [47:0] ONES  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] CMD0  = 48'h40_0000_0000_95;
  localparam logic [47:0] CMD8  = 48'h48_0000_01AA_87;
  localparam logic [47:0] FRM_B = 48'h41_2345_6789_AB;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Card model: SCK rises capture MOSI; after the 48 command bits the card
  // drives its queued response bits on each falling edge (idle high).
  initial begin
    forever begin
      @(posedge bus.sck);
      mosi_cap.push_back(bus.mosi);
      rise_t.push_back($time);
      rise_cnt++;
    end
  end

  initial begin
    forever begin
      @(negedge bus.sck);
      if (rise_cnt >= 48) begin
        if (card_bits.size() != 0) bus.miso = card_bits.pop_front();
        else bus.miso = 1'b1;
      end
    end
  end

  task automatic clear_mon();
    rise_cnt = 0;
    mosi_cap.delete();
    rise_t.delete();
    card_bits.delete();
    bus.miso = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) card_bits.push_back(b[i]);
  endtask

  function automatic logic [47:0] cap_frame(input bit msb);
    logic [47:0] f;
    f = 'x;
    for (int i = 0; i < 48; i++) begin
      if (i < mosi_cap.size()) begin
        if (msb) f[47-i] = mosi_cap[i];
        else     f[i]    = mosi_cap[i];
      end
    end
    return f;
  endfunction

  function automatic int count_zeros(input int from, input int to);
    int n;
    n = 0;
    for (int i = from; i < to; i++) begin
      if (i >= mosi_cap.size() || mosi_cap[i] !== 1'b1) n++;
    end
    return n;
  endfunction

  // Called at a negedge; the DUT starts on the following posedge.
  task automatic start_txn(input logic [47:0] frame, input logic [8:0] st, input bit hold);
    bus.data   = frame;
    bus.status = st | 9'h001;
    @(negedge clk);
    check("busy_after_start", bus.flag, 3'b001);
    if (!hold) bus.status[0] = 1'b0;
  endtask

  // Returns at the negedge where flag shows done/timeout; 3'b111 if the budget expires.
  task automatic wait_end(output logic [2:0] f);
    int n;
    f = 3'b111;
    for (n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (bus.flag == 3'b010 || bus.flag == 3'b100) begin
        f = bus.flag;
        break;
      end
    end
  endtask

  logic [2:0] f;
  time        t0;
  int         n;

  initial begin
    bus.data   = '0;
    bus.status = '0;
    rst_n      = 1'b0;
    clear_mon();
    repeat (2) @(negedge clk);

    check("rst_sck",  bus.sck,  1'b0);
    check("rst_mosi", bus.mosi, 1'b1);
    check("rst_ss",   bus.ss,   1'b1);
    check("rst_r1",   bus.r1,   8'hFF);
    check("rst_resp", bus.resp, 32'h0);
    check("rst_flag", bus.flag, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // All-ones dummy frame, sel=2 (H=4), SS=1, MSB first.
    clear_mon();
    start_txn(ONES, 9'h087, 1'b0);
    t0 = $time;
    check("t1_ss", bus.ss, 1'b1);
    wait_end(f);
    check("t1_flag",   f, 3'b010);
    check("t1_sck_lo", bus.sck, 1'b0);
    check("t1_rises",  rise_cnt, 48);
    check("t1_r1",     bus.r1, 8'hFF);
    check("t1_mosi1",  count_zeros(0, rise_cnt), 0);
    check("t1_period", (rise_t.size() >= 2) ? rise_t[1] - rise_t[0] : 0, 80);
    check("t1_lead",   (rise_t.size() >= 1) ? rise_t[0] - t0 : 0, 35);
    @(negedge clk);
    check("t1_flag_after", bus.flag, 3'b000);

    // CMD0, sel=0, SS=0, MSB first; card answers FF FF 01.
    clear_mon();
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h01);
    start_txn(CMD0, 9'h005, 1'b0);
    check("t2_ss", bus.ss, 1'b0);
    wait_end(f);
    check("t2_flag",   f, 3'b010);
    check("t2_rises",  rise_cnt, 72);
    check("t2_frame",  cap_frame(1'b1), CMD0);
    check("t2_mosi_r", count_zeros(48, 72), 0);
    check("t2_r1",     bus.r1, 8'h01);
    @(negedge clk);
    check("t2_flag_after", bus.flag, 3'b000);

    // CMD8 with long response: R1=01 then 000001AA.
    clear_mon();
    push_byte(8'h01); push_byte(8'h00); push_byte(8'h00);
    push_byte(8'h01); push_byte(8'hAA);
    start_txn(CMD8, 9'h025, 1'b0);
    wait_end(f);
    check("t3_flag",  f, 3'b010);
    check("t3_rises", rise_cnt, 88);
    check("t3_frame", cap_frame(1'b1), CMD8);
    check("t3_r1",    bus.r1, 8'h01);
    check("t3_resp",  bus.resp, 32'h0000_01AA);

    // MISO stuck high: NCR_MAX bytes then timeout.
    @(negedge clk);
    clear_mon();
    start_txn(CMD0, 9'h005, 1'b0);
    wait_end(f);
    check("t4_flag",  f, 3'b100);
    check("t4_rises", rise_cnt, 48 + 64);
    check("t4_r1",    bus.r1, 8'hFF);
    check("t4_sck_lo", bus.sck, 1'b0);
    @(negedge clk);
    check("t4_flag_after", bus.flag, 3'b000);

    // Request held high: second (LSB-first) frame starts the cycle after DONE.
    clear_mon();
    push_byte(8'h05);
    start_txn(CMD0, 9'h005, 1'b1);
    wait_end(f);
    check("t5a_flag",  f, 3'b010);
    check("t5a_frame", cap_frame(1'b1), CMD0);
    check("t5a_r1",    bus.r1, 8'h05);
    bus.data   = FRM_B;
    bus.status = 9'h001;
    clear_mon();
    push_byte(8'h01);
    @(negedge clk);
    check("t5_b2b_busy", bus.flag, 3'b001);
    check("t5_b2b_sck",  bus.sck, 1'b0);
    bus.status[0] = 1'b0;
    wait_end(f);
    check("t5b_flag",  f, 3'b010);
    check("t5b_rises", rise_cnt, 56);
    check("t5b_frame", cap_frame(1'b0), FRM_B);
    check("t5b_r1",    bus.r1, 8'h01);
    @(negedge clk);

    // Reset pulsed at command bit 20, then a clean command.
    clear_mon();
    start_txn(CMD0, 9'h005, 1'b0);
    for (n = 0; n < 1000; n++) begin
      if (rise_cnt >= 20) break;
      @(negedge clk);
    end
    check("t6_reached_bit20", rise_cnt, 20);
    rst_n = 1'b0;
    #1;
    check("t6_rst_sck",  bus.sck,  1'b0);
    check("t6_rst_mosi", bus.mosi, 1'b1);
    check("t6_rst_ss",   bus.ss,   1'b1);
    check("t6_rst_r1",   bus.r1,   8'hFF);
    check("t6_rst_resp", bus.resp, 32'h0);
    check("t6_rst_flag", bus.flag, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    push_byte(8'h01);
    start_txn(CMD0, 9'h005, 1'b0);
    wait_end(f);
    check("t6_flag",  f, 3'b010);
    check("t6_rises", rise_cnt, 56);
    check("t6_frame", cap_frame(1'b1), CMD0);
    check("t6_r1",    bus.r1, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_cmd_engine.md
Name: spi_cmd_engine

Overview:
- SPI master shift engine directly downstream of the SD-card init sequencer and the micro command path.
- Takes a 48-bit command frame plus the 9-bit SPI status register and generates SCK_SPI, MOSI and SS (mode 0).
- Captures the card's R1 byte, plus an optional 32-bit trailer (R3/R7), and returns R1 and the 3-bit flag register that the sequencer uses to advance.

Parameters:
- NCR_MAX, 8: maximum response-wait bytes after the command before timeout.
- FRAME_BITS, 48: command frame length in bits.

Ports:
- spi_clk_i  in  1  system clock, all logic on posedge.
- spi_rst_ni  in  1  asynchronous, active-low reset.
- spi_data_i  in  48  command frame, sampled at transaction start.
- spi_statusreg_i  in  9  bits:
  - [8:6] SCK divider select (sel).
  - [5] long response.
  - [4:3] reserved.
  - [2] MSB first.
  - [1] SS level.
  - [0] operation request.
- spi_miso_i  in  1  card data out.
- SCK_SPI  out  1  SPI clock, idle low.
- spi_mosi_o  out  1  card data in.
- spi_ss_o  out  1  chip select, active low.
- R1  out  8  last captured R1 byte.
- spi_resp_o  out  32  trailer bytes, valid when long response is set.
- spi_flagreg_o  out  3  000 idle, 001 busy, 010 done, 100 timeout.

Behaviour:
- Reset values:
  - SCK_SPI=0, spi_mosi_o=1, spi_ss_o=1, R1=8'hFF, spi_resp_o=0, spi_flagreg_o=000.
  - FSM in IDLE, all counters 0.
- Half period H = 2^sel spi_clk_i cycles. sel=0 gives H=1; sel=5 gives SCK = clk/64. sel is latched at start.
- FSM states: IDLE, SHIFT_CMD, WAIT_R1, SHIFT_RESP, DONE, TOUT.
- IDLE, when spi_statusreg_i[0]=1:
  - Latch data and status.
  - spi_ss_o <= status[1].
  - spi_mosi_o <= first bit: bit 47 if [2]=1, else bit 0.
  - flag <= 001; go to SHIFT_CMD. SCK stays low.
- Half-period counter: counts H cycles, then toggles SCK.
  - Rising edge: sample spi_miso_i into the receive shift register.
  - Falling edge: present the next bit on MOSI.
  - The first bit is stable H cycles before the first rising edge.
- SHIFT_CMD ends after 48 rising edges plus the trailing falling edge.
  - Frame [47:46]==2'b01 (valid command): go to WAIT_R1.
  - Otherwise (dummy/wait frame, e.g. all ones): R1 <= 8'hFF, go to DONE with no response phase.
- WAIT_R1:
  - MOSI held 1; clock byte-aligned 8-bit bytes.
  - After each byte, if byte[7]==0: R1 <= byte, then go to SHIFT_RESP if long response is set, else DONE.
  - Otherwise increment the byte count. When the count reaches NCR_MAX, R1 <= 8'hFF and go to TOUT.
- SHIFT_RESP: MOSI=1; clock 32 bits MSB-first into spi_resp_o, then go to DONE.
- DONE: flag=010 for exactly one cycle, SCK low, then IDLE with flag 000.
- TOUT: flag=100 for exactly one cycle, SCK low, then IDLE with flag 000.
- Back-to-back transactions: request held high across DONE starts the next transaction on the cycle after DONE. New data/status are sampled at that point, so the upstream sequencer may change the frame during the DONE cycle.
- Request deasserted mid-transaction: ignored; the transaction completes.
- spi_ss_o: holds the latched value between transactions and changes only at a start.
- Reset mid-transaction: everything returns to reset values immediately (async); no partial flag pulse.
- Status bits [4:3]: ignored.

Test Plan:
- All-ones frame, sel=2, SS=1 -> 48 SCK pulses, period 8 clk; MOSI constantly 1; spi_ss_o=1; one-cycle flag 010; R1=FF; no response bytes clocked.
- CMD0 frame 48'h400000000095, SS=0, MSB first; MISO returns FF,FF,01 -> MOSI bits match the frame MSB-first; exactly 3 response bytes clocked; R1=01; flag 010 for one cycle.
- CMD8 frame 48'h48000001AA87, long response set; MISO returns 01 then 00 00 01 AA -> R1=01, spi_resp_o=32'h000001AA, 40 response SCK pulses.
- Valid frame with MISO stuck high -> exactly NCR_MAX=8 response bytes; R1=FF; flag 100 for one cycle; then flag 000.
- Request held high across two commands -> second transaction starts the cycle after DONE with the new frame, no idle SCK pulse; LSB-first frame (status[2]=0) shifts bit 0 first.
- spi_rst_ni pulsed low at bit 20 of a command -> outputs return immediately to reset values; the next request starts a clean 48-bit frame.
